// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment display blocks.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    BLANK
  } scan_state_e;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment encoder.
// Non-decimal nibbles render as a dark digit.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed scan controller for a 4-digit common-anode display:
// per-digit dwell, optional blanking gap, leading-zero blank, registered outputs.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [4*NUM_DIGITS-1:0]       bcd,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          lzb,
  output logic [$clog2(NUM_DIGITS)-1:0] sel,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [6:0]                    seg,
  output logic                          dp
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int CNT_W   = $clog2((CNT_MAX < 2) ? 2 : CNT_MAX);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);

  scan_state_e                   state_q;
  logic [CNT_W-1:0]              cnt_q;
  logic [$clog2(NUM_DIGITS)-1:0] sel_q;
  logic [NUM_DIGITS-1:0]         an_q;
  logic [6:0]                    seg_q;
  logic                          dp_q;

  // Values loaded into the output registers when a SHOW slot begins.
  logic [$clog2(NUM_DIGITS)-1:0] entry_dig;
  logic [3:0]                    entry_nib;
  logic [6:0]                    entry_seg;
  logic [NUM_DIGITS-1:0]         entry_an;
  logic                          entry_dp;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    entry_dig = sel_q;
    if (state_q == IDLE)      entry_dig = '0;
    else if (state_q == SHOW) entry_dig = sel_q + 2'd1;
    entry_nib = bcd[{entry_dig, 2'b00} +: 4];
    entry_an  = ~(NUM_DIGITS'(1) << entry_dig);
    if (entry_dig == 2'd3 && lzb && entry_nib == 4'd0) entry_an = '1;
    entry_dp  = ~dp_in[entry_dig];
  end

  bcd_to_seg u_enc (
    .bcd_i (entry_nib),
    .seg_o (entry_seg)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    // A dropped enable abandons the slot exactly like reset does.
    if (rst || !en) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      an_q    <= '1;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= SHOW;
          cnt_q   <= '0;
          sel_q   <= '0;
          an_q    <= entry_an;
          seg_q   <= entry_seg;
          dp_q    <= entry_dp;
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            cnt_q <= '0;
            sel_q <= sel_q + 2'd1;
            if (BLANK_CYC == 0) begin
              state_q <= SHOW;
              an_q    <= entry_an;
              seg_q   <= entry_seg;
              dp_q    <= entry_dp;
            end else begin
              state_q <= BLANK;
              an_q    <= '1;
              seg_q   <= SEG_OFF;
              dp_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_q <= SHOW;
            cnt_q   <= '0;
            an_q    <= entry_an;
            seg_q   <= entry_seg;
            dp_q    <= entry_dp;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel = sel_q;
  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
